vga_timing_gen: RTL and testbench

- Parametrised VGA/raster timing generator; successor to the fixed-count sync pulse block.
- Produces H/V sync with programmable polarity, plus pixel position, active-video and line/frame markers.
- Sits between the pixel-clock domain and any pixel source (pattern gen, framebuffer reader) and drives the VGA connector.
- Counts pixels, not raw clocks: advances only on a pixel clock-enable, so one system clock serves any pixel rate.

---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 88 ++++++++
 tb/tb_vga_timing_gen.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the pixel enable going into the generator and the
// registered sync, position and marker outputs going to the pixel source and connector.
interface vga_timing_gen_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 10
);
  logic             CE;
  logic             H_pulse;
  logic             V_pulse;
  logic             ACTIVE;
  logic [COL_W-1:0] COL;
  logic [ROW_W-1:0] ROW;
  logic             LINE_START;
  logic             FRAME_START;

  // CE is a qualifier, not a handshake: the generator advances one pixel on
  // every clock where CE=1, and all outputs are valid every clock.
  modport master (
    input  CE,
    output H_pulse, V_pulse, ACTIVE, COL, ROW, LINE_START, FRAME_START
  );

  modport slave (
    output CE,
    input  H_pulse, V_pulse, ACTIVE, COL, ROW, LINE_START, FRAME_START
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters advanced by a pixel
// enable, with every sync and marker output registered alongside the position.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10
) (
  input  logic             CLK,
  input  logic             RST,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compare constants carry one extra bit so a sync region ending exactly at
  // 2^COL_W (zero back porch, full-width counter) does not wrap to zero.
  localparam logic [COL_W:0] H_LAST      = (COL_W+1)'(H_TOTAL - 1);
  localparam logic [COL_W:0] H_ACT_END   = (COL_W+1)'(H_ACTIVE);
  localparam logic [COL_W:0] H_SYNC_BEG  = (COL_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COL_W:0] H_SYNC_END  = (COL_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W:0] V_LAST      = (ROW_W+1)'(V_TOTAL - 1);
  localparam logic [ROW_W:0] V_ACT_END   = (ROW_W+1)'(V_ACTIVE);
  localparam logic [ROW_W:0] V_SYNC_BEG  = (ROW_W+1)'(V_ACTIVE + V_FP);
  localparam logic [ROW_W:0] V_SYNC_END  = (ROW_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [COL_W:0]   col_x;
  logic [ROW_W:0]   row_x;
  logic             h_in_sync;
  logic             v_in_sync;
  logic             in_active;

  always_comb begin
    col_nxt = vga.COL;
    row_nxt = vga.ROW;
    if (vga.CE) begin
      if ({1'b0, vga.COL} < H_LAST) begin
        col_nxt = vga.COL + 1'b1;
      end else begin
        col_nxt = '0;
        if ({1'b0, vga.ROW} < V_LAST) row_nxt = vga.ROW + 1'b1;
        else                          row_nxt = '0;
      end
    end
  end

  // Flags are decoded from the next position so they land in the same
  // register stage as COL/ROW and never lag the position by a cycle.
  always_comb begin
    col_x     = {1'b0, col_nxt};
    row_x     = {1'b0, row_nxt};
    h_in_sync = (col_x >= H_SYNC_BEG) && (col_x < H_SYNC_END);
    v_in_sync = (row_x >= V_SYNC_BEG) && (row_x < V_SYNC_END);
    in_active = (col_x < H_ACT_END) && (row_x < V_ACT_END);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vga.COL         <= '0;
      vga.ROW         <= '0;
      vga.H_pulse     <= ~H_POL;
      vga.V_pulse     <= ~V_POL;
      vga.ACTIVE      <= 1'b1;
      vga.LINE_START  <= 1'b1;
      vga.FRAME_START <= 1'b1;
    end else begin
      vga.COL         <= col_nxt;
      vga.ROW         <= row_nxt;
      vga.H_pulse     <= h_in_sync ? H_POL : ~H_POL;
      vga.V_pulse     <= v_in_sync ? V_POL : ~V_POL;
      vga.ACTIVE      <= in_active;
      vga.LINE_START  <= (col_nxt == '0);
      vga.FRAME_START <= (col_nxt == '0) && (row_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations driven from one RST/CE pair and
// checked against a pixel-count model (position = advances mod totals).
module tb_vga_timing_gen;
  localparam int N = 4;

  // Configurations: 0 defaults, 1 inverted polarity with short frame,
  // 2 tiny timing, 3 tiny timing with zero H front porch and V back porch.
  int ha [N]  = '{640, 640, 4, 4};
  int hfp[N]  = '{16,  16,  1, 0};
  int hs [N]  = '{96,  96,  2, 2};
  int hbp[N]  = '{48,  48,  1, 1};
  int va [N]  = '{480, 20,  3, 3};
  int vfp[N]  = '{10,  2,   1, 1};
  int vs [N]  = '{2,   2,   1, 1};
  int vbp[N]  = '{33,  3,   1, 0};
  bit hpol[N] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit vpol[N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic clk;
  logic rst;
  logic ce;
  int   n_chk;
  int   n_fail;
  longint adv;

  logic [9:0] o_col[N];
  logic [9:0] o_row[N];
  logic [4:0] o_flg[N];

  vga_timing_gen_if #(.COL_W(10), .ROW_W(10)) v0 ();
  vga_timing_gen_if #(.COL_W(10), .ROW_W(10)) v1 ();
  vga_timing_gen_if #(.COL_W(10), .ROW_W(10)) v2 ();
  vga_timing_gen_if #(.COL_W(10), .ROW_W(10)) v3 ();

  assign v0.CE = ce;
  assign v1.CE = ce;
  assign v2.CE = ce;
  assign v3.CE = ce;

  vga_timing_gen dut0 (.CLK(clk), .RST(rst), .vga(v0));

  vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1),
                   .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut1 (
    .CLK(clk), .RST(rst), .vga(v1));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut2 (
    .CLK(clk), .RST(rst), .vga(v2));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(0)) dut3 (
    .CLK(clk), .RST(rst), .vga(v3));

  assign o_col[0] = v0.COL;
  assign o_col[1] = v1.COL;
  assign o_col[2] = v2.COL;
  assign o_col[3] = v3.COL;
  assign o_row[0] = v0.ROW;
  assign o_row[1] = v1.ROW;
  assign o_row[2] = v2.ROW;
  assign o_row[3] = v3.ROW;
  assign o_flg[0] = {v0.H_pulse, v0.V_pulse, v0.ACTIVE, v0.LINE_START, v0.FRAME_START};
  assign o_flg[1] = {v1.H_pulse, v1.V_pulse, v1.ACTIVE, v1.LINE_START, v1.FRAME_START};
  assign o_flg[2] = {v2.H_pulse, v2.V_pulse, v2.ACTIVE, v2.LINE_START, v2.FRAME_START};
  assign o_flg[3] = {v3.H_pulse, v3.V_pulse, v3.ACTIVE, v3.LINE_START, v3.FRAME_START};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: number of pixel advances since the last reset.
  always @(posedge clk) begin
    if (rst)     adv <= 0;
    else if (ce) adv <= adv + 1;
  end

  // ---------------- model ----------------
  function automatic int htot(int k);
    return ha[k] + hfp[k] + hs[k] + hbp[k];
  endfunction

  function automatic int vtot(int k);
    return va[k] + vfp[k] + vs[k] + vbp[k];
  endfunction

  function automatic int ecol(int k);
    return int'(adv % longint'(htot(k)));
  endfunction

  function automatic int erow(int k);
    return int'((adv / longint'(htot(k))) % longint'(vtot(k)));
  endfunction

  function automatic logic [4:0] eflg(int k);
    int c;
    int r;
    bit h;
    bit v;
    c = ecol(k);
    r = erow(k);
    h = (c >= ha[k] + hfp[k]) && (c < ha[k] + hfp[k] + hs[k]);
    v = (r >= va[k] + vfp[k]) && (r < va[k] + vfp[k] + vs[k]);
    return {h ? hpol[k] : ~hpol[k], v ? vpol[k] : ~vpol[k],
            (c < ha[k]) && (r < va[k]), c == 0, (c == 0) && (r == 0)};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      for (int k = 0; k < N; k++) begin
        n_chk++;
        if (o_col[k] !== 10'd0 || o_row[k] !== 10'd0) begin
          n_fail++;
          $display("FAIL reset_pos dut%0d: got col=%0d row=%0d expected 0,0", k, o_col[k], o_row[k]);
        end
        n_chk++;
        if (o_flg[k] !== {~hpol[k], ~vpol[k], 3'b111}) begin
          n_fail++;
          $display("FAIL reset_flags dut%0d: got %b expected %b", k, o_flg[k], {~hpol[k], ~vpol[k], 3'b111});
        end
      end
    end
  endtask

  task automatic test_free_run();
    int last_fs2;
    int last_fs3;
    int h_cnt;
    int a_cnt;
    int v_cnt;
    last_fs2 = -1;
    last_fs3 = -1;
    h_cnt = 0;
    a_cnt = 0;
    v_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 21600; i++) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < N; k++) begin
        n_chk++;
        if (o_col[k] !== 10'(ecol(k)) || o_row[k] !== 10'(erow(k))) begin
          n_fail++;
          $display("FAIL free_run_pos dut%0d cyc %0d: got %0d,%0d expected %0d,%0d", k, i, o_col[k], o_row[k], ecol(k), erow(k));
        end
        n_chk++;
        if (o_flg[k] !== eflg(k)) begin
          n_fail++;
          $display("FAIL free_run_flags dut%0d cyc %0d: got %b expected %b", k, i, o_flg[k], eflg(k));
        end
      end
      if (i < 1600 && o_flg[0][4] == 1'b0) h_cnt++;
      if (i < 1600 && o_flg[0][2] == 1'b1) a_cnt++;
      if (o_flg[1][3] == 1'b1) v_cnt++;
      if (o_flg[2][0] == 1'b1) begin
        if (last_fs2 >= 0) begin
          n_chk++;
          if (i - last_fs2 != 48) begin
            n_fail++;
            $display("FAIL frame_period_small: got %0d expected 48", i - last_fs2);
          end
        end
        last_fs2 = i;
      end
      if (o_flg[3][0] == 1'b1) begin
        if (last_fs3 >= 0) begin
          n_chk++;
          if (i - last_fs3 != 35) begin
            n_fail++;
            $display("FAIL frame_period_zero_porch: got %0d expected 35", i - last_fs3);
          end
        end
        last_fs3 = i;
      end
    end
    n_chk++;
    if (h_cnt != 192) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d low clocks expected 192", h_cnt);
    end
    n_chk++;
    if (a_cnt != 1280) begin
      n_fail++;
      $display("FAIL active_count: got %0d expected 1280", a_cnt);
    end
    n_chk++;
    if (v_cnt != 1600) begin
      n_fail++;
      $display("FAIL vsync_width_pol: got %0d high clocks expected 1600", v_cnt);
    end
  endtask

  task automatic test_sparse_ce();
    int last_fs;
    last_fs = -1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'(i % 4 == 3));
      for (int k = 0; k < N; k++) begin
        n_chk++;
        if (o_col[k] !== 10'(ecol(k)) || o_row[k] !== 10'(erow(k)) || o_flg[k] !== eflg(k)) begin
          n_fail++;
          $display("FAIL sparse_ce dut%0d cyc %0d: got %0d,%0d,%b expected %0d,%0d,%b", k, i,
                   o_col[k], o_row[k], o_flg[k], ecol(k), erow(k), eflg(k));
        end
      end
      // Frame start of the tiny config marks its first clock at (0,0).
      if (o_flg[2][0] == 1'b1 && i % 4 == 3) begin
        if (last_fs >= 0) begin
          n_chk++;
          if (i - last_fs != 192) begin
            n_fail++;
            $display("FAIL sparse_frame_period: got %0d expected 192", i - last_fs);
          end
        end
        last_fs = i;
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b1);
    for (int i = 0; i < 1900; i++) step(1'b0, 1'b1);
    n_chk++;
    if (o_col[0] !== 10'd300 || o_row[0] !== 10'd2) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got %0d,%0d expected 300,2", o_col[0], o_row[0]);
    end
    step(1'b1, 1'b1);
    n_chk++;
    if (o_col[0] !== 10'd0 || o_row[0] !== 10'd0 || o_flg[0] !== 5'b11111) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d,%0d,%b expected 0,0,11111", o_col[0], o_row[0], o_flg[0]);
    end
    step(1'b0, 1'b1);
    n_chk++;
    if (o_col[0] !== 10'd1 || o_row[0] !== 10'd0 || o_flg[0] !== 5'b11100) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %0d,%0d,%b expected 1,0,11100", o_col[0], o_row[0], o_flg[0]);
    end
  endtask

  task automatic test_random_ce();
    step(1'b1, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)));
      for (int k = 0; k < N; k++) begin
        n_chk++;
        if (o_col[k] !== 10'(ecol(k)) || o_row[k] !== 10'(erow(k)) || o_flg[k] !== eflg(k)) begin
          n_fail++;
          $display("FAIL random_ce dut%0d cyc %0d: got %0d,%0d,%b expected %0d,%0d,%b", k, i,
                   o_col[k], o_row[k], o_flg[k], ecol(k), erow(k), eflg(k));
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    ce     = 1'b0;
    test_reset();
    test_free_run();
    test_sparse_ce();
    test_mid_reset();
    test_random_ce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
